// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, zero-register index and packed-slice helpers
// for regfile_mp and its scoreboard (rev 1.0).
`default_nettype none

package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_REG  = 0;

  function automatic int addr_width(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

  // Low bit of field 'port' inside a packed vector of 'width'-bit fields.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with set/clear/flush priority
// and a registered popcount of the pending set (rev 1.0).
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr,
  input  logic             flush,
  output logic [NREGS-1:0] pending,
  output logic [AW:0]      busy_cnt
);

  localparam int CW = AW + 1;

  logic [NREGS-1:0] pend_q, pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             w_set, w_clr, w_inc, w_dec;

  assign w_set = busy_set && (busy_addr != AW'(ZERO_REG));
  assign w_clr = wr_en && (wr_addr != AW'(ZERO_REG));
  // A same-address set keeps the bit, so that write must not decrement.
  assign w_inc = w_set && !pend_q[busy_addr];
  assign w_dec = w_clr && pend_q[wr_addr] && !(w_set && (busy_addr == wr_addr));

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q + CW'(w_inc) - CW'(w_dec);
    if (w_clr) pend_d[wr_addr] = 1'b0;
    if (w_set) pend_d[busy_addr] = 1'b1;
    if (flush) begin
      pend_d = '0;
      cnt_d  = '0;
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending  = pend_q;
  assign busy_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with x0 tied to zero and a pending-write
// scoreboard; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding (rev 1.0).
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              busy_set,
  input  logic [AW-1:0]     busy_addr,
  input  logic              flush,
  output logic [AW:0]       busy_cnt,
  output logic              any_busy
);

  logic [XLEN-1:0]  w_rf [NREGS];
  logic [NREGS-1:0] w_pend;
  logic             w_wr_hit;

  assign w_wr_hit = wr_en && (wr_addr != AW'(ZERO_REG));
  assign w_rf[0]  = '0;

  // Entry 0 has no flop; every other entry is its own register.
  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    logic [XLEN-1:0] data_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
      end else if (w_wr_hit && (wr_addr == AW'(r))) begin
        data_q <= wr_data;
      end
    end
    assign w_rf[r] = data_q;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[port_lo(p, AW) +: AW];
`ifdef REGFILE_BYPASS_EN
    logic fwd;
    assign fwd = w_wr_hit && (wr_addr == addr);
    assign rd_data[port_lo(p, XLEN) +: XLEN] = fwd ? wr_data : w_rf[addr];
    assign rd_busy[p] = !fwd && w_pend[addr];
`else
    assign rd_data[port_lo(p, XLEN) +: XLEN] = w_rf[addr];
    assign rd_busy[p] = w_pend[addr];
`endif
  end

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_set (busy_set),
    .busy_addr(busy_addr),
    .flush    (flush),
    .pending  (w_pend),
    .busy_cnt (busy_cnt)
  );

  assign any_busy = (busy_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table and corner-case sequences for regfile_mp
// (NREGS=16, XLEN=64, NRD=4).
`default_nettype none

module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NRD   = 4;
  localparam int AW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              busy_set;
  logic [AW-1:0]     busy_addr;
  logic              flush;
  logic [AW:0]       busy_cnt;
  logic              any_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .flush(flush), .busy_cnt(busy_cnt), .any_busy(any_busy)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [63:0] wd;
    logic        bs;
    logic [3:0]  ba;
    logic        fl;
    logic [3:0]  ra;
    logic [63:0] ed;
    logic        eb;
    logic [4:0]  ec;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_addr = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [63:0] exp_v;

  initial begin
    // {we, wa, wd, bs, ba, fl, ra, exp data, exp busy, exp cnt}; read never hits this cycle's write
    tv[0]  = '{1'b1, 4'd5, 64'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd1, 64'h0,        1'b0, 5'd0};
    tv[1]  = '{1'b0, 4'd0, 64'h0,        1'b1, 4'd7, 1'b0, 4'd5, 64'hDEADBEEF, 1'b0, 5'd0};
    tv[2]  = '{1'b0, 4'd0, 64'h0,        1'b1, 4'd9, 1'b0, 4'd7, 64'h0,        1'b1, 5'd1};
    tv[3]  = '{1'b1, 4'd7, 64'h77,       1'b0, 4'd0, 1'b0, 4'd9, 64'h0,        1'b1, 5'd2};
    tv[4]  = '{1'b1, 4'd0, 64'hFFFFFFFF, 1'b0, 4'd0, 1'b0, 4'd7, 64'h77,       1'b0, 5'd1};
    tv[5]  = '{1'b0, 4'd0, 64'h0,        1'b1, 4'd0, 1'b0, 4'd0, 64'h0,        1'b0, 5'd1};
    tv[6]  = '{1'b1, 4'd9, 64'h99,       1'b1, 4'd9, 1'b0, 4'd7, 64'h77,       1'b0, 5'd1};
    tv[7]  = '{1'b0, 4'd0, 64'h0,        1'b0, 4'd0, 1'b0, 4'd9, 64'h99,       1'b1, 5'd1};
    tv[8]  = '{1'b0, 4'd0, 64'h0,        1'b1, 4'd9, 1'b0, 4'd9, 64'h99,       1'b1, 5'd1};
    tv[9]  = '{1'b0, 4'd0, 64'h0,        1'b1, 4'd1, 1'b0, 4'd0, 64'h0,        1'b0, 5'd1};
    tv[10] = '{1'b0, 4'd0, 64'h0,        1'b1, 4'd2, 1'b0, 4'd1, 64'h0,        1'b1, 5'd2};
    tv[11] = '{1'b0, 4'd0, 64'h0,        1'b1, 4'd3, 1'b0, 4'd2, 64'h0,        1'b1, 5'd3};
    tv[12] = '{1'b1, 4'd6, 64'h66,       1'b1, 4'd4, 1'b1, 4'd3, 64'h0,        1'b1, 5'd4};
    tv[13] = '{1'b0, 4'd0, 64'h0,        1'b0, 4'd0, 1'b0, 4'd6, 64'h66,       1'b0, 5'd0};
    tv[14] = '{1'b0, 4'd0, 64'h0,        1'b0, 4'd0, 1'b0, 4'd4, 64'h0,        1'b0, 5'd0};

    rst = 1'b1;
    idle();
    rd_addr = {4'd0, 4'd5, 4'd9, 4'd15};
    #3;
    for (int p = 0; p < NRD; p++) begin
      chk("reset rd_data", rd_data[p*XLEN +: XLEN], 64'h0);
    end
    chk("reset rd_busy", 64'(rd_busy), 64'h0);
    chk("reset busy_cnt", 64'(busy_cnt), 64'h0);
    chk("reset any_busy", 64'(any_busy), 64'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
      busy_set = tv[i].bs; busy_addr = tv[i].ba; flush = tv[i].fl;
      rd_addr = {4{tv[i].ra}};
      #1;
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("vec%0d rd_data[%0d]", i, p), rd_data[p*XLEN +: XLEN], tv[i].ed);
      end
      chk($sformatf("vec%0d rd_busy", i), 64'(rd_busy[0]), 64'(tv[i].eb));
      chk($sformatf("vec%0d busy_cnt", i), 64'(busy_cnt), 64'(tv[i].ec));
      chk($sformatf("vec%0d any_busy", i), 64'(any_busy), 64'(tv[i].ec != 5'd0));
      tick();
    end

    // Write x3 with a new producer in the same cycle, read it on all ports
    idle();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 64'h12345678;
    busy_set = 1'b1; busy_addr = 4'd3;
    rd_addr = {4{4'd3}};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 64'h12345678;
`else
    exp_v = 64'h0;
`endif
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("wcycle x3 port%0d", p), rd_data[p*XLEN +: XLEN], exp_v);
      chk($sformatf("wcycle x3 busy%0d", p), 64'(rd_busy[p]), 64'h0);
    end
    tick();
    idle();
    #1;
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("next x3 port%0d", p), rd_data[p*XLEN +: XLEN], 64'h12345678);
      chk($sformatf("next x3 busy%0d", p), 64'(rd_busy[p]), 64'h1);
    end
    chk("x3 busy_cnt", 64'(busy_cnt), 64'd1);

    // Fill all registers with index-derived patterns and read back
    for (int i = 1; i < NREGS; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 64'(i) * 64'h0101010101010101;
      tick();
    end
    idle();
    for (int i = 1; i < NREGS; i++) begin
      rd_addr = {4{4'(i)}};
      #1;
      chk($sformatf("fill x%0d", i), rd_data[(i % NRD)*XLEN +: XLEN],
          64'(i) * 64'h0101010101010101);
    end
    chk("fill busy_cnt", 64'(busy_cnt), 64'd0);

    // Mark every register pending, re-mark one, then flush
    for (int i = 1; i < NREGS; i++) begin
      busy_set = 1'b1; busy_addr = 4'(i);
      tick();
    end
    busy_addr = 4'd5;
    tick();
    idle();
    #1;
    chk("all pending busy_cnt", 64'(busy_cnt), 64'd15);
    chk("all pending any_busy", 64'(any_busy), 64'd1);
    flush = 1'b1;
    tick();
    idle();
    #1;
    chk("flush busy_cnt", 64'(busy_cnt), 64'd0);
    chk("flush any_busy", 64'(any_busy), 64'd0);

    // Asynchronous reset mid-stream with a write in flight
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 64'hDEADBEEF;
    busy_set = 1'b1; busy_addr = 4'd5;
    tick();
    idle();
    rd_addr = {4{4'd5}};
    #1;
    chk("pre-reset x5", rd_data[0 +: XLEN], 64'hDEADBEEF);
    chk("pre-reset busy_cnt", 64'(busy_cnt), 64'd1);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 64'hCAFE;
    rst = 1'b1;
    #1;
    chk("async reset x5", rd_data[0 +: XLEN], 64'h0);
    chk("async reset busy", 64'(rd_busy[0]), 64'h0);
    chk("async reset busy_cnt", 64'(busy_cnt), 64'd0);
    chk("async reset any_busy", 64'(any_busy), 64'd0);
    tick();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 64'h88;
    tick();
    idle();
    rd_addr = {4'd5, 4'd5, 4'd5, 4'd8};
    #1;
    chk("post-reset first write x8", rd_data[0 +: XLEN], 64'h88);
    chk("post-reset lost write x5", rd_data[XLEN +: XLEN], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file with a per-register pending-write scoreboard, for the next-generation RISC-V core. It sits in decode: it supplies source operands to the ALU/branch path and accepts writeback from the WB stage. It also tracks which architectural registers have an outstanding producer, for example a multi-cycle load, so decode can stall on RAW hazards. x0 is hard-wired to zero.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of architectural registers; must be a power of two and ≥ 2. AW = log2(NREGS).
- NRD, 2: number of independent read ports, 1..4.
- clk  in  1: single clock; all state updates on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- rd_addr  in  NRD*AW: read addresses; port p occupies bits [p*AW +: AW].
- rd_data  out  NRD*XLEN: read data, port p at [p*XLEN +: XLEN].
- rd_busy  out  NRD: port p's register has a pending write.
- wr_en  in  1: writeback strobe.
- wr_addr  in  AW: writeback destination.
- wr_data  in  XLEN: writeback data.
- busy_set  in  1: a producer issued; mark busy_addr pending.
- busy_addr  in  AW: destination being marked pending.
- flush  in  1: clear all pending flags (pipeline flush).
- busy_cnt  out  AW+1: number of registers currently pending.
- any_busy  out  1: busy_cnt != 0.

## Operation
- Storage: NREGS-1 physical registers (1..NREGS-1). Reg 0 has no storage.
  - Reading address 0 returns 0 with rd_busy = 0.
  - Writes and busy_set targeting address 0 are ignored.
- Read: combinational, per port, independent. Multiple ports may read the same address.
- Write: when wr_en = 1 and wr_addr != 0, regs[wr_addr] <= wr_data at the clock edge.
- Scoreboard: one pending bit per register 1..NREGS-1.
  - busy_set sets pending[busy_addr].
  - A write to a pending register clears its bit.
  - busy_set and wr_en to the same address in the same cycle: the bit ends set (new producer wins); the data is still written.
  - busy_set on an already-pending register: the bit stays set; busy_cnt is unchanged.
  - A write to a non-pending register leaves the bit clear.
  - flush = 1 clears every pending bit and overrides busy_set in that cycle. A write in the same cycle still updates data.
- busy_cnt is a registered counter kept equal to the popcount of the pending bits.
  - Per cycle it changes by -1, 0 or +1; flush forces it to 0.
  - It can never exceed NREGS-1.

## Timing
- Reset (async assert):
  - all registers = 0, all pending bits = 0, busy_cnt = 0, any_busy = 0.
  - rd_data = 0 and rd_busy = 0 for every address.
- Reset release is synchronous to clk. The first edge after deassert may perform a write.
- Reset asserted mid-operation: state clears immediately, without waiting for an edge. Any in-flight write is lost.
- Write latency: data is visible on rd_data in the cycle after the wr_en edge, unless the bypass is compiled in (see Configuration).
- Pending bits, busy_cnt and any_busy update one cycle after busy_set, wr_en or flush.

## Configuration
- REGFILE_BYPASS_EN defined:
  - write-through forwarding. When wr_en = 1, wr_addr != 0 and wr_addr == rd_addr[p], rd_data[p] = wr_data and rd_busy[p] = 0 in the same cycle.
  - If busy_set targets the same register in that cycle, rd_busy[p] = 0 still holds for this cycle.
  - Zero-latency write-to-read.
- Undefined: no forwarding. A read in the write cycle returns the old value and the old rd_busy. Decode must insert one bubble.

## Structure
- Shared package regfile_pkg:
  - default XLEN/NREGS/NRD localparams;
  - ZERO_REG = 0;
  - a clog2-based address-width function;
  - the packed port-slice helpers.
- Sub-module regfile_scoreboard: pending bit vector, set/clear/flush priority, busy_cnt counter. The top holds storage, read muxes and bypass.

## Test plan
- Reset check: assert rst mid-stream after writing 0xDEADBEEF to x5. Required: rd_data for x5 = 0 immediately; busy_cnt = 0.
- x0 handling:
  - wr_en, wr_addr=0, wr_data=0xFFFFFFFF, then read x0. Required: 0.
  - busy_set with busy_addr=0. Required: busy_cnt stays 0.
- Write then read, NRD=4: write x3=0x12345678, then read x3 on all four ports.
  - Bypass build: same-cycle value 0x12345678.
  - Non-bypass build: old value that cycle, 0x12345678 the next cycle.
- Scoreboard:
  - busy_set x7 then x9. Required: busy_cnt = 2.
  - Write x7. Required: rd_busy(x7) = 0, busy_cnt = 1.
  - busy_set x9 and write x9 in the same cycle. Required: bit set, busy_cnt = 1.
- Flush: set x1, x2, x3 pending, then flush together with busy_set x4. Required: busy_cnt = 0 and any_busy = 0 the next cycle.
- Parameters: NREGS=16, XLEN=64. Write all 15 registers with their index and read them back. Required: all values correct and no aliasing.
